// File: rtl/draw_pkg.sv
// draw_pkg: constants and types shared by the frame-buffer draw path.
//   DRAW_* : frame geometry and frame-buffer port widths (same values the draw block uses)
//   POS_W / FRAC_W : unsigned fixed-point particle position format
//   plot_state_t : particle_plotter FSM states
package draw_pkg;

  localparam int unsigned DRAW_WIDTH  = 640;
  localparam int unsigned DRAW_HEIGHT = 480;
  localparam int unsigned DRAW_SIZE   = DRAW_WIDTH * DRAW_HEIGHT;
  localparam int unsigned DRAW_ADDRW  = $clog2(DRAW_SIZE);
  localparam int unsigned DRAW_DATAW  = 1;

  localparam int unsigned POS_W  = 16;
  localparam int unsigned FRAC_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    PLOT,
    DRAIN
  } plot_state_t;

endpackage

// File: rtl/particle_plotter_if.sv
// particle_plotter_if: bundles the plotter's control handshake, particle-memory read port and
// frame-buffer write port.
//   master : plotter side (drives busy/done, particle reads and frame-buffer writes)
//   slave  : environment side (drives start, returns particle positions)
interface particle_plotter_if #(
  parameter int unsigned PART_ADDRW = 8,
  parameter int unsigned DRAW_ADDRW = draw_pkg::DRAW_ADDRW,
  parameter int unsigned DRAW_DATAW = draw_pkg::DRAW_DATAW,
  parameter int unsigned POS_W      = draw_pkg::POS_W
);

  logic                  start;
  logic                  busy;
  logic                  done;
  logic                  part_rd_en;
  logic [PART_ADDRW-1:0] part_rd_addr;
  logic [POS_W-1:0]      part_x;
  logic [POS_W-1:0]      part_y;
  logic [DRAW_ADDRW-1:0] draw_addr_write;
  logic [DRAW_DATAW-1:0] draw_data_in;
  logic                  draw_we;

  modport master (
    input  start,
    output busy,
    output done,
    output part_rd_en,
    output part_rd_addr,
    input  part_x,
    input  part_y,
    output draw_addr_write,
    output draw_data_in,
    output draw_we
  );

  modport slave (
    output start,
    input  busy,
    input  done,
    input  part_rd_en,
    input  part_rd_addr,
    output part_x,
    output part_y,
    input  draw_addr_write,
    input  draw_data_in,
    input  draw_we
  );

endinterface

// File: rtl/pos_to_pixel_addr.sv
// pos_to_pixel_addr: converts a fixed-point (x, y) position into a frame-buffer address.
// Purely combinational; shared with the cursor path.
//   pos_x, pos_y : unsigned fixed-point position (FRAC_W fractional bits)
//   addr         : py*DRAW_WIDTH + px, only meaningful when in_range
//   in_range     : integer position lies inside the frame
module pos_to_pixel_addr #(
  parameter int unsigned POS_W       = draw_pkg::POS_W,
  parameter int unsigned FRAC_W      = draw_pkg::FRAC_W,
  parameter int unsigned DRAW_WIDTH  = draw_pkg::DRAW_WIDTH,
  parameter int unsigned DRAW_HEIGHT = draw_pkg::DRAW_HEIGHT,
  parameter int unsigned DRAW_ADDRW  = draw_pkg::DRAW_ADDRW
) (
  input  logic [POS_W-1:0]      pos_x,
  input  logic [POS_W-1:0]      pos_y,
  output logic [DRAW_ADDRW-1:0] addr,
  output logic                  in_range
);

  logic [POS_W-1:0] px;
  logic [POS_W-1:0] py;

  always_comb begin
    // Truncate the fraction, no rounding.
    px = pos_x >> FRAC_W;
    py = pos_y >> FRAC_W;
    // Compare at 33 bits so neither side can wrap whatever POS_W and the frame size are.
    in_range = (33'(px) < 33'(DRAW_WIDTH)) && (33'(py) < 33'(DRAW_HEIGHT));
    // Only in-range results are used, and those cannot overflow DRAW_ADDRW bits.
    addr = DRAW_ADDRW'(py) * DRAW_ADDRW'(DRAW_WIDTH) + DRAW_ADDRW'(px);
  end

endmodule

// File: rtl/particle_plotter.sv
// particle_plotter: renders one frame of particles into the 1-bit frame buffer.
// On start: clears every pixel, then reads every particle position and lights its pixel.
//   clk, rst : simulation clock, synchronous active-high reset
//   bus      : start/busy/done handshake, particle read port (1-cycle read latency),
//              frame-buffer write port. All outputs are registered.
// Frame time is DRAW_SIZE + N_PARTICLES + 3 cycles from the accepting edge to done.
module particle_plotter #(
  parameter int unsigned DRAW_WIDTH  = draw_pkg::DRAW_WIDTH,
  parameter int unsigned DRAW_HEIGHT = draw_pkg::DRAW_HEIGHT,
  parameter int unsigned DRAW_SIZE   = DRAW_WIDTH * DRAW_HEIGHT,
  parameter int unsigned DRAW_ADDRW  = $clog2(DRAW_SIZE),
  parameter int unsigned DRAW_DATAW  = draw_pkg::DRAW_DATAW,
  parameter int unsigned N_PARTICLES = 256,
  parameter int unsigned PART_ADDRW  = (N_PARTICLES > 1) ? $clog2(N_PARTICLES) : 1,
  parameter int unsigned POS_W       = draw_pkg::POS_W,
  parameter int unsigned FRAC_W      = draw_pkg::FRAC_W
) (
  input  logic               clk,
  input  logic               rst,
  particle_plotter_if.master bus
);

  import draw_pkg::*;

  localparam int unsigned CNT_MAX = (DRAW_ADDRW > PART_ADDRW) ? DRAW_ADDRW : PART_ADDRW;
  localparam int unsigned CNT_W   = (CNT_MAX > 2) ? CNT_MAX : 2;

  localparam logic [CNT_W-1:0] LAST_PIX   = CNT_W'(DRAW_SIZE - 1);
  localparam logic [CNT_W-1:0] LAST_PART  = CNT_W'(N_PARTICLES - 1);
  // Two plot-pipeline stages (memory read, address register) after the last issue.
  localparam logic [CNT_W-1:0] LAST_DRAIN = CNT_W'(2);

  plot_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic pix_vld_q;  // part_x/part_y carry a valid position this cycle

  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  part_rd_en_q, part_rd_en_d;
  logic [PART_ADDRW-1:0] part_rd_addr_q, part_rd_addr_d;
  logic [DRAW_ADDRW-1:0] draw_addr_q, draw_addr_d;
  logic [DRAW_DATAW-1:0] draw_data_q, draw_data_d;
  logic                  draw_we_q, draw_we_d;

  logic [DRAW_ADDRW-1:0] pix_addr;
  logic                  pix_in_range;
  logic                  start_ok;

  pos_to_pixel_addr #(
    .POS_W      (POS_W),
    .FRAC_W     (FRAC_W),
    .DRAW_WIDTH (DRAW_WIDTH),
    .DRAW_HEIGHT(DRAW_HEIGHT),
    .DRAW_ADDRW (DRAW_ADDRW)
  ) u_pos_to_pixel_addr (
    .pos_x   (bus.part_x),
    .pos_y   (bus.part_y),
    .addr    (pix_addr),
    .in_range(pix_in_range)
  );

  // IDLE is entered in the done cycle; a start there is ignored.
  assign start_ok = bus.start && !done_q;

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      pix_vld_q      <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      part_rd_en_q   <= 1'b0;
      part_rd_addr_q <= '0;
      draw_addr_q    <= '0;
      draw_data_q    <= '0;
      draw_we_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      pix_vld_q      <= part_rd_en_q;
      busy_q         <= busy_d;
      done_q         <= done_d;
      part_rd_en_q   <= part_rd_en_d;
      part_rd_addr_q <= part_rd_addr_d;
      draw_addr_q    <= draw_addr_d;
      draw_data_q    <= draw_data_d;
      draw_we_q      <= draw_we_d;
    end
  end

  // Next state. cnt_q is the next pixel / particle index to emit, or the drain cycle count.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start_ok) begin
          state_d = CLEAR;
          cnt_d   = CNT_W'(1);  // pixel 0 is written on the accepting edge
        end
      end
      CLEAR: begin
        if (cnt_q == LAST_PIX) begin
          state_d = PLOT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PLOT: begin
        if (cnt_q == LAST_PART) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DRAIN: begin
        if (cnt_q == LAST_DRAIN) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Next values of the registered outputs.
  always_comb begin
    busy_d         = 1'b0;
    done_d         = 1'b0;
    part_rd_en_d   = 1'b0;
    part_rd_addr_d = part_rd_addr_q;
    draw_we_d      = 1'b0;
    draw_addr_d    = draw_addr_q;
    draw_data_d    = draw_data_q;
    unique case (state_q)
      IDLE: begin
        if (start_ok) begin
          busy_d      = 1'b1;
          draw_we_d   = 1'b1;
          draw_addr_d = '0;
          draw_data_d = '0;
        end
      end
      CLEAR: begin
        busy_d      = 1'b1;
        draw_we_d   = 1'b1;
        draw_addr_d = DRAW_ADDRW'(cnt_q);
        draw_data_d = '0;
      end
      PLOT: begin
        busy_d         = 1'b1;
        part_rd_en_d   = 1'b1;
        part_rd_addr_d = PART_ADDRW'(cnt_q);
      end
      DRAIN: begin
        busy_d = (cnt_q != LAST_DRAIN);
        done_d = (cnt_q == LAST_DRAIN);
      end
      default: ;
    endcase
    // Plot writes only occur while PLOT/DRAIN are active, never overlapping a clear write.
    if (pix_vld_q && pix_in_range) begin
      draw_we_d   = 1'b1;
      draw_addr_d = pix_addr;
      draw_data_d = DRAW_DATAW'(1);
    end
  end

  assign bus.busy            = busy_q;
  assign bus.done            = done_q;
  assign bus.part_rd_en      = part_rd_en_q;
  assign bus.part_rd_addr    = part_rd_addr_q;
  assign bus.draw_addr_write = draw_addr_q;
  assign bus.draw_data_in    = draw_data_q;
  assign bus.draw_we         = draw_we_q;

endmodule

// File: tb/tb_particle_plotter.sv
module tb_particle_plotter;

  localparam int unsigned W     = 8;
  localparam int unsigned H     = 4;
  localparam int unsigned SIZE  = W * H;
  localparam int unsigned ADDRW = 5;
  localparam int unsigned N     = 4;
  localparam int unsigned PAW   = 2;
  localparam int unsigned POSW  = 16;
  localparam int unsigned FRAC  = 4;
  localparam int unsigned FRAME = SIZE + N + 3;

  logic clk;
  logic rst;

  int n_tests;
  int n_fail;

  // Particle memory contents and the model's view of the held write address/data.
  logic [POSW-1:0] mem_x [N];
  logic [POSW-1:0] mem_y [N];
  int last_addr;
  int last_data;

  particle_plotter_if #(
    .PART_ADDRW(PAW),
    .DRAW_ADDRW(ADDRW),
    .DRAW_DATAW(1),
    .POS_W     (POSW)
  ) bus ();

  particle_plotter #(
    .DRAW_WIDTH (W),
    .DRAW_HEIGHT(H),
    .N_PARTICLES(N),
    .POS_W      (POSW),
    .FRAC_W     (FRAC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Particle memory: one-cycle read latency, garbage when not read.
  always @(posedge clk) begin
    if (bus.part_rd_en) begin
      bus.part_x <= mem_x[bus.part_rd_addr];
      bus.part_y <= mem_y[bus.part_rd_addr];
    end else begin
      bus.part_x <= POSW'($urandom);
      bus.part_y <= POSW'($urandom);
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Compare every output in the cycle that is rel cycles after the accepting edge.
  task automatic check_cycle(input int rel);
    int exp_busy, exp_done, exp_rd, exp_we;
    int px, py, i;
    exp_busy = (rel >= 1 && rel <= int'(SIZE + N + 2)) ? 1 : 0;
    exp_done = (rel == int'(FRAME)) ? 1 : 0;
    exp_rd   = (rel >= int'(SIZE + 1) && rel <= int'(SIZE + N)) ? 1 : 0;
    exp_we   = 0;
    if (rel >= 1 && rel <= int'(SIZE)) begin
      exp_we    = 1;
      last_addr = rel - 1;
      last_data = 0;
    end else if (rel >= int'(SIZE + 3) && rel <= int'(SIZE + N + 2)) begin
      i  = rel - int'(SIZE) - 3;
      px = int'(mem_x[i]) / (1 << FRAC);
      py = int'(mem_y[i]) / (1 << FRAC);
      if (px < int'(W) && py < int'(H)) begin
        exp_we    = 1;
        last_addr = py * int'(W) + px;
        last_data = 1;
      end
    end
    check($sformatf("busy@%0d", rel), int'(bus.busy), exp_busy);
    check($sformatf("done@%0d", rel), int'(bus.done), exp_done);
    check($sformatf("rd_en@%0d", rel), int'(bus.part_rd_en), exp_rd);
    if (exp_rd == 1)
      check($sformatf("rd_addr@%0d", rel), int'(bus.part_rd_addr), rel - int'(SIZE) - 1);
    check($sformatf("we@%0d", rel), int'(bus.draw_we), exp_we);
    check($sformatf("addr@%0d", rel), int'(bus.draw_addr_write), last_addr);
    check($sformatf("data@%0d", rel), int'(bus.draw_data_in), last_data);
  endtask

  task automatic check_idle(input string tag, input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      check({tag, "_busy"}, int'(bus.busy), 0);
      check({tag, "_done"}, int'(bus.done), 0);
      check({tag, "_rd_en"}, int'(bus.part_rd_en), 0);
      check({tag, "_we"}, int'(bus.draw_we), 0);
      check({tag, "_addr"}, int'(bus.draw_addr_write), last_addr);
      check({tag, "_data"}, int'(bus.draw_data_in), last_data);
    end
  endtask

  // Raise start for one edge (or keep it high when hold=1) and check up to last_rel.
  task automatic run_frame(input bit hold, input int last_rel);
    @(posedge clk);
    #1 bus.start = 1'b1;
    @(posedge clk);
    #1 if (!hold) bus.start = 1'b0;
    for (int rel = 1; rel <= last_rel; rel++) begin
      @(negedge clk);
      check_cycle(rel);
    end
  endtask

  task automatic set_pos(input int i, input int x, input int y);
    mem_x[i] = POSW'(x);
    mem_y[i] = POSW'(y);
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    last_addr = 0;
    last_data = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    for (int i = 0; i < int'(N); i++) set_pos(i, 0, 0);

    // Reset and idle.
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_idle("reset_idle", 50);

    // Directed plot addresses: 11, 0, 31, 26.
    set_pos(0, 'h35, 'h12);
    set_pos(1, 'h00, 'h00);
    set_pos(2, 'h7F, 'h3F);
    set_pos(3, 'h20, 'h30);
    run_frame(1'b0, FRAME);
    check_idle("post_frame", 3);

    // Out of range in x and in y.
    set_pos(0, 'h80, 'h00);
    set_pos(1, 'h10, 'h10);
    set_pos(2, 'h00, 'h40);
    set_pos(3, 'h70, 'h30);
    run_frame(1'b0, FRAME);
    check_idle("post_oor", 2);

    // Randomised frames, some near the frame edges, one with full-range positions.
    for (int f = 0; f < 5; f++) begin
      for (int i = 0; i < int'(N); i++) begin
        if (f == 4) set_pos(i, int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)));
        else set_pos(i, int'($urandom_range(0, 16 * 11)), int'($urandom_range(0, 16 * 6)));
      end
      run_frame(1'b0, FRAME);
      check_idle("post_rand", int'($urandom_range(1, 3)));
    end

    // start held through the frame and the done cycle: accepted again only after done.
    run_frame(1'b1, FRAME);
    run_frame(1'b1, FRAME);
    #1 bus.start = 1'b0;
    check_idle("post_hold", 3);

    // Reset mid-frame: rst in cycle 20, all outputs 0 from cycle 21, no done.
    run_frame(1'b0, 19);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    last_addr = 0;
    last_data = 0;
    check_idle("after_rst", 45);

    for (int i = 0; i < int'(N); i++)
      set_pos(i, int'($urandom_range(0, 16 * 9)), int'($urandom_range(0, 16 * 5)));
    run_frame(1'b0, FRAME);
    check_idle("final", 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
